adex_param_stream_tx: RTL and testbench

- Transmit side of the AdEx neuron nibble-serial parameter-load protocol.
- Accepts a 64-bit parameter word with a start pulse and drives load_mode, load_enable and a 4-bit nibble bus.
- The frame is one header strobe, 16 data nibbles (8 bytes, high nibble first) and a footer nibble 0xF; it makes the neuron's loader commit the new parameter set.
- Sits on-chip between a config source (SPI or test controller) and the neuron's ui_in[4:3] / uio_in[3:0] pins.

---
 rtl/adex_cfg_pkg.sv | 21 ++
 rtl/adex_param_stream_tx.sv | 108 ++++++++++
 tb/tb_adex_param_stream_tx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/adex_cfg_pkg.sv
// adex_cfg_pkg: frame constants, param byte offsets, FSM states and nibble selection for the AdEx loader
package adex_cfg_pkg;
  localparam logic [3:0] FOOTER_NIB = 4'hF;
  localparam logic [3:0] HEADER_NIB = 4'h0;
  localparam int N_PARAMS = 8;
  localparam int N_STROBES = 18;
  localparam int DELTAT_OFS = 0;
  localparam int TAUW_OFS = 8;
  localparam int A_OFS = 16;
  localparam int B_OFS = 24;
  localparam int VRESET_OFS = 32;
  localparam int VT_OFS = 40;
  localparam int IBIAS_OFS = 48;
  localparam int C_OFS = 56;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE_H, STROBE_L, HOLD, KILL_H, KILL_L} state_t;
  function automatic logic [3:0] nib_sel(input logic [63:0] p, input logic [4:0] k);
    logic [3:0] j;
    j = 4'(k - 5'd1);
    return k == 5'd0 ? HEADER_NIB : k >= 5'(N_STROBES - 1) ? FOOTER_NIB : p[{j[3:1], ~j[0], 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/adex_param_stream_tx.sv
// adex_param_stream_tx: nibble-serial frame transmitter (header, 16 data nibbles, footer) with abort/kill strobe
module adex_param_stream_tx
  import adex_cfg_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int STROBE_HI = 2,
  parameter int STROBE_LO = 2,
  parameter int HOLD_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] params,
  output logic        load_mode,
  output logic        load_enable,
  output logic [3:0]  nibble_out,
  output logic        busy,
  output logic        done,
  output logic        aborted
);
  state_t state, state_n;
  logic [7:0] phase, phase_n;
  logic [4:0] k, k_n;
  logic kill, kill_n, done_n, aborted_n;
  logic [63:0] shadow;
  logic hi_end, lo_end, last_k;
  assign hi_end = phase == 8'(STROBE_HI - 1);
  assign lo_end = phase == 8'(STROBE_LO - 1);
  assign last_k = k == 5'(N_STROBES - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      phase <= '0;
      k <= '0;
      kill <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      shadow <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      k <= k_n;
      kill <= kill_n;
      done <= done_n;
      aborted <= aborted_n;
      if (state == IDLE && start) shadow <= params;
    end
  end
  always_comb begin
    state_n = state;
    phase_n = phase + 8'd1;
    k_n = k;
    kill_n = kill;
    done_n = 1'b0;
    aborted_n = 1'b0;
    case (state)
      IDLE: begin
        phase_n = '0;
        k_n = '0;
        kill_n = 1'b0;
        state_n = start ? SETUP : IDLE;
      end
      SETUP: if (phase == 8'(SETUP_CYC - 1)) begin
        state_n = STROBE_H;
        phase_n = '0;
      end
      STROBE_H: if (hi_end) begin
        state_n = STROBE_L;
        phase_n = '0;
      end
      STROBE_L: if (kill || lo_end) begin
        phase_n = '0;
        state_n = kill ? KILL_H : last_k ? HOLD : STROBE_H;
        k_n = (kill || last_k) ? k : k + 5'd1;
      end
      HOLD: if (phase == 8'(HOLD_CYC - 1)) begin
        state_n = IDLE;
        done_n = 1'b1;
      end
      KILL_H: if (hi_end) begin
        state_n = KILL_L;
        phase_n = '0;
      end
      KILL_L: if (lo_end) begin
        state_n = IDLE;
        aborted_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // Once the receiver waits for the footer only a zero-nibble strobe returns it to idle
    if (abort && !kill && state inside {SETUP, STROBE_H, STROBE_L, HOLD}) begin
      phase_n = '0;
      done_n = 1'b0;
      if (state != HOLD && !last_k) begin
        state_n = IDLE;
        aborted_n = 1'b1;
      end else begin
        kill_n = 1'b1;
        state_n = state == STROBE_H ? STROBE_L : KILL_H;
      end
    end
  end
  assign busy = state != IDLE;
  assign load_mode = busy && !kill;
  assign load_enable = state == STROBE_H || state == KILL_H;
  assign nibble_out = (state == STROBE_H || state == STROBE_L) && !kill ? nib_sel(shadow, k) : 4'h0;
endmodule

// File: tb/tb_adex_param_stream_tx.sv
// tb_adex_param_stream_tx: table-driven and randomized frame checks against a cycle-arithmetic model
module tb_adex_param_stream_tx;
  localparam int S = 2, H = 2, L = 2, HD = 4, P = H + L;
  localparam int FRAME = 1 + S + 18 * P + HD;
  logic clk = 1'b0;
  logic reset, start, abort, f_start, f_abort;
  logic [63:0] params;
  logic lm, le, busy, done, aborted;
  logic [3:0] nib;
  logic f_lm, f_le, f_busy, f_done, f_ab;
  logic [3:0] f_nib;
  int vectors = 0, miscompares = 0;
  logic [3:0] rec[$];
  typedef struct {
    logic [63:0] p;
    int abort_cyc, restart_cyc, reset_cyc, exp_end, exp_edges;
    bit exp_done, exp_abt;
  } vec_t;
  vec_t tbl[8];

  adex_param_stream_tx dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .params(params),
    .load_mode(lm), .load_enable(le), .nibble_out(nib), .busy(busy), .done(done), .aborted(aborted)
  );
  adex_param_stream_tx #(.SETUP_CYC(1), .STROBE_HI(1), .STROBE_LO(1), .HOLD_CYC(2)) u_fast (
    .clk(clk), .reset(reset), .start(f_start), .abort(f_abort), .params(params),
    .load_mode(f_lm), .load_enable(f_le), .nibble_out(f_nib), .busy(f_busy), .done(f_done), .aborted(f_ab)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] model_nib(input logic [63:0] p, input int k);
    logic [7:0] b;
    if (k == 0) return 4'h0;
    if (k >= 17) return 4'hF;
    b = 8'(p >> (8 * ((k - 1) / 2)));
    return (k % 2 == 1) ? b[7:4] : b[3:0];
  endfunction

  // Expected outcome of a default-timing frame given the cycle an abort is applied (<=0: none)
  task automatic model(input int a, output int e_end, output int e_edges, output bit e_done, output bit e_abt);
    int t, k, ph;
    e_done = 1'b0;
    e_abt = 1'b1;
    if (a <= 0) begin
      e_end = FRAME; e_edges = 18; e_done = 1'b1; e_abt = 1'b0;
    end else if (a <= S) begin
      e_end = a + 1; e_edges = 0;
    end else if (a >= 1 + S + 18 * P) begin
      e_end = a + 1 + H + L; e_edges = 19;
    end else begin
      t = a - (S + 1); k = t / P; ph = t % P;
      if (k < 17) begin
        e_end = a + 1; e_edges = k + 1;
      end else begin
        e_end = (ph < H) ? a + 2 + H + L : a + 1 + H + L; e_edges = 19;
      end
    end
  endtask

  task automatic run(input logic [63:0] p, input int abort_cyc, input int restart_cyc, input int reset_cyc,
                     input int exp_end, input int exp_edges, input bit exp_done, input bit exp_abt);
    int c, lm_edges;
    bit prev, ok, fin;
    logic [3:0] cur;
    rec.delete();
    c = 0; lm_edges = 0; prev = 1'b0; ok = 1'b1; cur = 4'h0;
    params = p; start = 1'b1; abort = (abort_cyc == 0);
    do begin
      @(negedge clk);
      c++;
      fin = done || aborted || c == reset_cyc + 1 || c >= 400;
      if (!fin) begin
        if (!busy) ok = 1'b0;
        if (le && !prev) begin
          rec.push_back(nib);
          cur = nib;
          if (lm) lm_edges++;
        end else if (le && nib !== cur) ok = 1'b0;
        prev = le;
        params = (c == restart_cyc) ? ~p : p;
        start = (c == restart_cyc);
        abort = (c == abort_cyc);
        reset = (c == reset_cyc);
      end
    end while (!fin);
    start = 1'b0; abort = 1'b0; reset = 1'b0;
    check("end_cycle", 64'(c), 64'(exp_end));
    check("done", done, exp_done);
    check("aborted", aborted, exp_abt);
    check("idle_outputs", {busy, lm, le, nib}, 0);
    check("edge_count", 64'(rec.size()), 64'(exp_edges));
    check("lm_at_edges", 64'(lm_edges), 64'(exp_edges > 18 ? 18 : exp_edges));
    for (int i = 0; i < rec.size(); i++)
      if (rec[i] !== (i < 18 ? model_nib(p, i) : 4'h0)) ok = 1'b0;
    check("nibbles_busy_stable", ok, 1'b1);
  endtask

  initial begin
    int e_end, e_edges, a, c, last_edge, min_gap;
    bit e_done, e_abt, ok;
    logic [63:0] rp;
    logic [3:0] gold[18];
    gold = '{4'h0, 4'h8, 4'h2, 4'h6, 4'h4, 4'h0, 4'h2, 4'h2, 4'h8, 4'h3, 4'hF, 4'h4, 4'hE, 4'h8, 4'h0, 4'hC, 4'h8, 4'hF};
    tbl[0] = '{64'hC8_80_4E_3F_28_02_64_82, -1, -1, -1, 79, 18, 1'b1, 1'b0};
    tbl[1] = '{64'hC8_80_4E_3F_28_02_64_82, -1, 10, -1, 79, 18, 1'b1, 1'b0};
    tbl[2] = '{64'h0123_4567_89AB_CDEF, 31, -1, -1, 32, 8, 1'b0, 1'b1};
    tbl[3] = '{64'hFEDC_BA98_7654_3210, 71, -1, -1, 77, 19, 1'b0, 1'b1};
    tbl[4] = '{64'hA5A5_5A5A_0F0F_F0F0, 76, -1, -1, 81, 19, 1'b0, 1'b1};
    tbl[5] = '{64'h1122_3344_5566_7788, -1, 20, 43, 44, 11, 1'b0, 1'b0};
    tbl[6] = '{64'hDEAD_BEEF_CAFE_F00D, 0, -1, -1, 79, 18, 1'b1, 1'b0};
    tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 2, -1, -1, 3, 0, 1'b0, 1'b1};
    reset = 1'b1; start = 1'b0; abort = 1'b0; f_start = 1'b0; f_abort = 1'b0; params = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {busy, lm, le, nib, done, aborted, f_busy, f_lm, f_le, f_nib, f_done, f_ab}, 0);
    reset = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_ignored", {busy, aborted}, 0);
    for (int i = 0; i < 8; i++) begin
      run(tbl[i].p, tbl[i].abort_cyc, tbl[i].restart_cyc, tbl[i].reset_cyc,
          tbl[i].exp_end, tbl[i].exp_edges, tbl[i].exp_done, tbl[i].exp_abt);
      if (i == 0) begin
        ok = 1'b1;
        for (int j = 0; j < 18; j++) if (rec[j] !== gold[j]) ok = 1'b0;
        check("golden_nibbles", ok, 1'b1);
      end
    end
    for (int i = 0; i < 12; i++) begin
      rp = {$urandom, $urandom};
      a = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, FRAME - 1));
      model(a, e_end, e_edges, e_done, e_abt);
      run(rp, a, -1, -1, e_end, e_edges, e_done, e_abt);
    end
    params = 64'hC8_80_4E_3F_28_02_64_82;
    f_start = 1'b1;
    rec.delete();
    c = 0; last_edge = -100; min_gap = 1000;
    do begin
      @(negedge clk);
      c++;
      f_start = 1'b0;
      if (f_le && !(c - last_edge == 1)) begin
        if (c - last_edge < min_gap) min_gap = c - last_edge;
        last_edge = c;
        rec.push_back(f_nib);
      end
    end while (!f_done && c < 200);
    check("fast_done_cycle", 64'(c), 40);
    check("fast_edge_count", 64'(rec.size()), 18);
    check("fast_min_gap", 64'(min_gap), 2);
    ok = 1'b1;
    for (int j = 0; j < rec.size(); j++) if (rec[j] !== model_nib(params, j)) ok = 1'b0;
    check("fast_nibbles", ok, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
